// File: rtl/conv_post.sv
// conv_post: rescales 16-bit convolution results to 8 bits (shift + optional
// clamp), tags them with end-of-row / end-of-frame markers from raster
// counters, and buffers them in a first-word-fall-through FIFO that feeds a
// ready/valid consumer. The upstream stage cannot be stalled, so a write into
// a full FIFO is dropped and latches a sticky overflow flag.
//
// Build option: define CONV_POST_SAT_EN to clamp scaled values above 255 to
// 255; leave it undefined to keep only the low byte of the shifted value.
module conv_post #(
  parameter int OUT_COLS = 3,
  parameter int OUT_ROWS = 3,
  parameter int SHIFT    = 2,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              in_data,
  input  logic                     in_valid,
  output logic [7:0]               out_data,
  output logic                     out_eol,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

  // Entry layout: {last, eol, byte}
  logic [9:0]    mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;

  logic [15:0]   scaled;
  logic [7:0]    pix;
  logic          eol, last;
  logic          full, empty;
  logic          push, pop, drop;
  logic [9:0]    head;

  // Scaling, raster tagging, FIFO handshakes and next-state computation
  always_comb begin
    scaled = in_data >> SHIFT;
`ifdef CONV_POST_SAT_EN
    pix = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
`else
    pix = scaled[7:0];
`endif

    eol   = (col_q == CW'(OUT_COLS - 1));
    last  = eol && (row_q == RW'(OUT_ROWS - 1));

    full  = (level_q == LW'(DEPTH));
    empty = (level_q == '0);
    head  = mem_q[rptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    pop   = !empty && out_ready;
    push  = in_valid && (!full || pop);
    drop  = in_valid && full && !pop;

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end

    // Raster position only moves for samples that actually enter the FIFO
    col_d = col_q;
    row_d = row_q;
    if (push) begin
      if (eol) begin
        col_d = '0;
        row_d = last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    overflow_d   = overflow_q | drop;
    frame_done_d = pop && head[9];
  end

  // Pointer, occupancy, raster and flag state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      col_q        <= col_d;
      row_q        <= row_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents need no reset because empty masks the head
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {last, eol, pix};
    end
  end

  // Head entry is shown directly (fall-through) and forced to 0 when empty
  always_comb begin
    out_valid  = !empty;
    out_data   = empty ? 8'h00 : head[7:0];
    out_eol    = !empty && head[8];
    out_last   = !empty && head[9];
    frame_done = frame_done_q;
    overflow   = overflow_q;
    level      = level_q;
  end

endmodule

// File: tb/tb_conv_post.sv
// tb_conv_post: directed vectors for conv_post with default parameters
// (3x3 output frame, SHIFT=2, DEPTH=16).
module tb_conv_post;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic [7:0]  out_data;
  logic        out_eol;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic        overflow;
  logic [4:0]  level;

  int n_vec;
  int n_err;

  conv_post #(
    .OUT_COLS(3),
    .OUT_ROWS(3),
    .SHIFT(2),
    .DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_eol(out_eol),
    .out_last(out_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_done(frame_done),
    .overflow(overflow),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse, checked while still asserted
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check_vec("rst_valid", 32'(out_valid), 32'd0);
    check_vec("rst_level", 32'(level), 32'd0);
    check_vec("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [15:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3;
    check_vec("init_valid", 32'(out_valid), 32'd0);
    check_vec("init_data", 32'(out_data), 32'd0);
    check_vec("init_eol", 32'(out_eol), 32'd0);
    check_vec("init_last", 32'(out_last), 32'd0);
    check_vec("init_fd", 32'(frame_done), 32'd0);
    check_vec("init_level", 32'(level), 32'd0);
    check_vec("init_ovf", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;

    // Single value: 0x40 >> 2 = 0x10
    push_one(16'h0040);
    check_vec("single_valid", 32'(out_valid), 32'd1);
    check_vec("single_data", 32'(out_data), 32'h10);
    check_vec("single_level", 32'(level), 32'd1);
    check_vec("single_eol", 32'(out_eol), 32'd0);
    do_reset();

    // Saturation: 0x800 >> 2 = 0x200
    push_one(16'h0800);
`ifdef CONV_POST_SAT_EN
    check_vec("sat_data", 32'(out_data), 32'hFF);
`else
    check_vec("sat_data", 32'(out_data), 32'h00);
`endif
    do_reset();

    // Full frame streamed with out_ready high: head i is visible after push i
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      in_data  = 16'(4 * i);
      in_valid = 1'b1;
      tick();
      check_vec($sformatf("frm%0d_data", i), 32'(out_data), 32'(i));
      check_vec($sformatf("frm%0d_eol", i), 32'(out_eol), 32'((i % 3) == 0));
      check_vec($sformatf("frm%0d_last", i), 32'(out_last), 32'(i == 9));
      check_vec($sformatf("frm%0d_level", i), 32'(level), 32'd1);
      check_vec($sformatf("frm%0d_fd", i), 32'(frame_done), 32'd0);
    end
    in_valid = 1'b0;
    tick();
    check_vec("frm_fd_pulse", 32'(frame_done), 32'd1);
    check_vec("frm_empty", 32'(out_valid), 32'd0);
    check_vec("frm_empty_data", 32'(out_data), 32'd0);
    tick();
    check_vec("frm_fd_low", 32'(frame_done), 32'd0);
    out_ready = 1'b0;
    do_reset();

    // Overflow: 17 pushes into 16 entries, 17th dropped
    for (int k = 1; k <= 17; k++) begin
      push_one(16'(4 * k));
      check_vec($sformatf("ovf_level%0d", k), 32'(level), 32'((k > 16) ? 16 : k));
      check_vec($sformatf("ovf_flag%0d", k), 32'(overflow), 32'(k == 17));
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      check_vec($sformatf("drn%0d_data", j), 32'(out_data), 32'(j));
      check_vec($sformatf("drn%0d_eol", j), 32'(out_eol), 32'((j % 3) == 0));
      check_vec($sformatf("drn%0d_last", j), 32'(out_last), 32'((j % 9) == 0));
      tick();
    end
    check_vec("drn_empty", 32'(out_valid), 32'd0);
    check_vec("drn_ovf_sticky", 32'(overflow), 32'd1);
    // Next sample is pixel 17 (col 1): a counted drop would make it col 2
    push_one(16'(4 * 50));
    check_vec("drn_next_data", 32'(out_data), 32'd50);
    check_vec("drn_next_eol", 32'(out_eol), 32'd0);
    tick();
    out_ready = 1'b0;
    do_reset();

    // Simultaneous push and pop while full
    for (int k = 1; k <= 16; k++) begin
      push_one(16'(4 * k));
    end
    check_vec("sim_full", 32'(level), 32'd16);
    in_data   = 16'(4 * 100);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_vec("sim_level", 32'(level), 32'd16);
    check_vec("sim_ovf", 32'(overflow), 32'd0);
    check_vec("sim_head", 32'(out_data), 32'd2);
    for (int j = 2; j <= 16; j++) begin
      tick();
    end
    check_vec("sim_new_head", 32'(out_data), 32'd100);
    check_vec("sim_new_level", 32'(level), 32'd1);
    tick();
    out_ready = 1'b0;
    do_reset();

    // Mid-frame reset: 5 pushes then an asynchronous reset pulse
    for (int k = 1; k <= 5; k++) begin
      push_one(16'(4 * k));
    end
    check_vec("mid_level", 32'(level), 32'd5);
    reset = 1'b1;
    #1;
    check_vec("mid_async_valid", 32'(out_valid), 32'd0);
    check_vec("mid_async_level", 32'(level), 32'd0);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push_one(16'(4 * k));
    end
    out_ready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      check_vec($sformatf("mid%0d_data", j), 32'(out_data), 32'(j));
      check_vec($sformatf("mid%0d_eol", j), 32'(out_eol), 32'(j == 3));
      check_vec($sformatf("mid%0d_last", j), 32'(out_last), 32'd0);
      tick();
    end
    check_vec("mid_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
